mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM encoding, streak default,
// and the saturating increment used by the data-streak counter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GNT_IF = 2'd1,
    ST_GNT_DS = 2'd2
  } arb_state_e;

  localparam int MAX_DS_STREAK_DEF = 4;
  localparam int STREAK_W          = 3;

  // Saturating +1 so a long data run cannot wrap the counter back to 0
  function automatic logic [STREAK_W-1:0] streak_inc(input logic [STREAK_W-1:0] s);
    return (s == {STREAK_W{1'b1}}) ? s : s + 1'b1;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch and data side share one
// single-cycle memory. Data wins by default; a fetch that has waited through
// MAX_DS_STREAK consecutive data grants takes the next slot.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_DS_STREAK = MAX_DS_STREAK_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_gnt,
  output logic        if_valid,
  output logic [15:0] if_rdata,
  input  logic        ds_req,
  input  logic        ds_we,
  input  logic [15:0] ds_addr,
  input  logic [15:0] ds_wdata,
  output logic        ds_gnt,
  output logic        ds_valid,
  output logic [15:0] ds_rdata,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_din,
  output logic        mem_rw,
  output logic        mem_en,
  input  logic [15:0] mem_dout
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DS_STREAK);

  arb_state_e          state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [15:0]         addr_q, addr_d;
  logic [15:0]         wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                if_valid_q, if_valid_d;
  logic                ds_valid_q, ds_valid_d;
  logic [15:0]         if_rdata_q, if_rdata_d;
  logic [15:0]         ds_rdata_q, ds_rdata_d;

  logic fetch_starved;
  assign fetch_starved = if_req && (streak_q == STREAK_MAX);

  // Next-state: arbitrate and latch the winner in IDLE, retire the access in GNT_*
  always_comb begin
    state_d    = state_q;
    streak_d   = streak_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    if_valid_d = 1'b0;
    ds_valid_d = 1'b0;
    if_rdata_d = if_rdata_q;
    ds_rdata_d = ds_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (ds_req && !fetch_starved) begin
          state_d  = ST_GNT_DS;
          addr_d   = ds_addr;
          we_d     = ds_we;
          wdata_d  = ds_wdata;
          // Only count data grants that actually made a fetch wait
          streak_d = if_req ? streak_inc(streak_q) : '0;
        end else if (if_req) begin
          state_d  = ST_GNT_IF;
          addr_d   = if_addr;
          we_d     = 1'b0;
          wdata_d  = '0;
          streak_d = '0;
        end else begin
          streak_d = '0;
        end
      end
      ST_GNT_IF: begin
        state_d    = ST_IDLE;
        if_valid_d = 1'b1;
        if_rdata_d = mem_dout;
      end
      ST_GNT_DS: begin
        state_d    = ST_IDLE;
        ds_valid_d = 1'b1;
        // Writes ack through ds_valid but leave the last read data in place
        if (!we_q) ds_rdata_d = mem_dout;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset wins over any arbitration on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      streak_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      if_valid_q <= 1'b0;
      ds_valid_q <= 1'b0;
      if_rdata_q <= '0;
      ds_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      if_valid_q <= if_valid_d;
      ds_valid_q <= ds_valid_d;
      if_rdata_q <= if_rdata_d;
      ds_rdata_q <= ds_rdata_d;
    end
  end

  // Memory-side drive decodes the current state, so a grant in flight during
  // a reset cycle still reaches the memory on that edge
  always_comb begin
    mem_en   = 1'b0;
    mem_rw   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if_gnt   = 1'b0;
    ds_gnt   = 1'b0;
    case (state_q)
      ST_GNT_IF: begin
        mem_en   = 1'b1;
        mem_addr = addr_q;
        if_gnt   = 1'b1;
      end
      ST_GNT_DS: begin
        mem_en   = 1'b1;
        mem_addr = addr_q;
        mem_rw   = we_q;
        mem_din  = wdata_q;
        ds_gnt   = 1'b1;
      end
      default: ;
    endcase
  end

  assign if_valid = if_valid_q;
  assign ds_valid = ds_valid_q;
  assign if_rdata = if_rdata_q;
  assign ds_rdata = ds_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-cycle memory.
// Inputs change and outputs are sampled on the falling edge.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_gnt, if_valid;
  logic [15:0] if_rdata;
  logic        ds_req, ds_we;
  logic [15:0] ds_addr, ds_wdata;
  logic        ds_gnt, ds_valid;
  logic [15:0] ds_rdata;
  logic [15:0] mem_addr, mem_din, mem_dout;
  logic        mem_rw, mem_en;

  // bench-side preload port into the memory model
  logic        ld_en;
  logic [15:0] ld_addr, ld_data;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_DS_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .ds_req(ds_req), .ds_we(ds_we), .ds_addr(ds_addr), .ds_wdata(ds_wdata),
    .ds_gnt(ds_gnt), .ds_valid(ds_valid), .ds_rdata(ds_rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_rw(mem_rw), .mem_en(mem_en),
    .mem_dout(mem_dout)
  );

  logic [15:0] mem [0:65535];
  assign mem_dout = mem[mem_addr];
  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (mem_en && mem_rw) mem[mem_addr] <= mem_din;
  end

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({if_gnt, ds_gnt, if_valid, ds_valid, mem_en, mem_rw} !== 6'b0 ||
        mem_addr !== 16'h0 || mem_din !== 16'h0 || if_rdata !== 16'h0 || ds_rdata !== 16'h0)
      $display("FAIL reset_outputs: gnt=%b%b vld=%b%b en=%b rw=%b addr=%h din=%h ird=%h drd=%h, want all 0",
               if_gnt, ds_gnt, if_valid, ds_valid, mem_en, mem_rw, mem_addr, mem_din, if_rdata, ds_rdata);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_idle;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (mem_en !== 1'b0 || if_valid !== 1'b0 || ds_valid !== 1'b0 || if_gnt !== 1'b0 || ds_gnt !== 1'b0)
        $display("FAIL idle_%0d: en=%b ivld=%b dvld=%b gnt=%b%b, want 0", i, mem_en, if_valid, ds_valid, if_gnt, ds_gnt);
      else passed++;
    end
  endtask

  task automatic test_fetch;
    preload(16'd12, 16'h1088);
    if_req = 1'b1; if_addr = 16'd12;
    @(negedge clk);
    checks++;
    if (if_gnt !== 1'b1 || ds_gnt !== 1'b0 || mem_en !== 1'b1 || mem_rw !== 1'b0 || mem_addr !== 16'd12 || mem_din !== 16'h0)
      $display("FAIL fetch_gnt: ig=%b dg=%b en=%b rw=%b addr=%h din=%h, want 1 0 1 0 000c 0000",
               if_gnt, ds_gnt, mem_en, mem_rw, mem_addr, mem_din);
    else passed++;
    if_req = 1'b0; if_addr = 16'hFFFF;
    @(negedge clk);
    checks++;
    if (if_valid !== 1'b1 || if_rdata !== 16'h1088 || if_gnt !== 1'b0 || mem_en !== 1'b0)
      $display("FAIL fetch_valid: vld=%b rdata=%h gnt=%b en=%b, want 1 1088 0 0", if_valid, if_rdata, if_gnt, mem_en);
    else passed++;
    @(negedge clk);
    checks++;
    if (if_valid !== 1'b0 || if_rdata !== 16'h1088)
      $display("FAIL fetch_pulse: vld=%b rdata=%h, want 0 1088", if_valid, if_rdata);
    else passed++;
  endtask

  task automatic test_data_wr_rd;
    ds_req = 1'b1; ds_we = 1'b1; ds_addr = 16'h0040; ds_wdata = 16'hBEEF;
    @(negedge clk);
    // requester inputs are don't-care once latched
    ds_req = 1'b0; ds_we = 1'b0; ds_addr = 16'h1234; ds_wdata = 16'h0000;
    checks++;
    if (ds_gnt !== 1'b1 || if_gnt !== 1'b0 || mem_en !== 1'b1 || mem_rw !== 1'b1 || mem_addr !== 16'h0040 || mem_din !== 16'hBEEF)
      $display("FAIL wr_gnt: dg=%b ig=%b en=%b rw=%b addr=%h din=%h, want 1 0 1 1 0040 beef",
               ds_gnt, if_gnt, mem_en, mem_rw, mem_addr, mem_din);
    else passed++;
    @(negedge clk);
    checks++;
    if (ds_valid !== 1'b1 || ds_rdata !== 16'h0000 || mem[16'h0040] !== 16'hBEEF)
      $display("FAIL wr_ack: vld=%b rdata=%h mem=%h, want 1 0000 beef", ds_valid, ds_rdata, mem[16'h0040]);
    else passed++;
    ds_req = 1'b1; ds_we = 1'b0; ds_addr = 16'h0040;
    @(negedge clk);
    ds_req = 1'b0;
    checks++;
    if (ds_gnt !== 1'b1 || mem_rw !== 1'b0 || mem_addr !== 16'h0040 || ds_valid !== 1'b0)
      $display("FAIL rd_gnt: dg=%b rw=%b addr=%h vld=%b, want 1 0 0040 0", ds_gnt, mem_rw, mem_addr, ds_valid);
    else passed++;
    @(negedge clk);
    checks++;
    if (ds_valid !== 1'b1 || ds_rdata !== 16'hBEEF)
      $display("FAIL rd_valid: vld=%b rdata=%h, want 1 beef", ds_valid, ds_rdata);
    else passed++;
  endtask

  task automatic test_both;
    preload(16'd20, 16'h5A5A);
    if_req = 1'b1; if_addr = 16'd20;
    ds_req = 1'b1; ds_we = 1'b0; ds_addr = 16'h0040;
    @(negedge clk);
    ds_req = 1'b0;
    checks++;
    if (ds_gnt !== 1'b1 || if_gnt !== 1'b0)
      $display("FAIL both_first: dg=%b ig=%b, want 1 0", ds_gnt, if_gnt);
    else passed++;
    @(negedge clk);
    checks++;
    if (ds_gnt !== 1'b0 || if_gnt !== 1'b0 || ds_valid !== 1'b1)
      $display("FAIL both_gap: dg=%b ig=%b dvld=%b, want 0 0 1", ds_gnt, if_gnt, ds_valid);
    else passed++;
    @(negedge clk);
    if_req = 1'b0;
    checks++;
    if (if_gnt !== 1'b1 || ds_gnt !== 1'b0 || mem_addr !== 16'd20)
      $display("FAIL both_second: ig=%b dg=%b addr=%h, want 1 0 0014", if_gnt, ds_gnt, mem_addr);
    else passed++;
    @(negedge clk);
    checks++;
    if (if_valid !== 1'b1 || if_rdata !== 16'h5A5A)
      $display("FAIL both_fetch_data: vld=%b rdata=%h, want 1 5a5a", if_valid, if_rdata);
    else passed++;
  endtask

  task automatic test_streak;
    string pat = "D.D.D.D.I.D.";
    logic [1:0] got, want;
    if_req = 1'b1; if_addr = 16'h0100;
    ds_req = 1'b1; ds_we = 1'b0; ds_addr = 16'hABCD;
    for (int i = 0; i < pat.len(); i++) begin
      @(negedge clk);
      got  = {if_gnt, ds_gnt};
      want = (pat[i] == "D") ? 2'b01 : (pat[i] == "I") ? 2'b10 : 2'b00;
      if (i == pat.len() - 1) begin if_req = 1'b0; ds_req = 1'b0; end
      checks++;
      if (got !== want)
        $display("FAIL streak_%0d: {if_gnt,ds_gnt}=%b, want %b", i, got, want);
      else passed++;
      if (want == 2'b01) begin
        checks++;
        if (mem_addr !== 16'hABCD)
          $display("FAIL streak_addr_%0d: mem_addr=%h, want abcd", i, mem_addr);
        else passed++;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_rst_during_write;
    ds_req = 1'b1; ds_we = 1'b1; ds_addr = 16'h0080; ds_wdata = 16'h1234;
    @(negedge clk);
    ds_req = 1'b0;
    checks++;
    if (ds_gnt !== 1'b1 || mem_rw !== 1'b1)
      $display("FAIL rstwr_gnt: dg=%b rw=%b, want 1 1", ds_gnt, mem_rw);
    else passed++;
    rst = 1'b1; if_req = 1'b1; if_addr = 16'd12;
    @(negedge clk);
    checks++;
    if (mem[16'h0080] !== 16'h1234)
      $display("FAIL rstwr_commit: mem=%h, want 1234", mem[16'h0080]);
    else passed++;
    checks++;
    if (ds_valid !== 1'b0 || dut.state_q !== ST_IDLE || {if_gnt, ds_gnt, if_valid, mem_en, mem_rw} !== 5'b0 ||
        mem_addr !== 16'h0 || mem_din !== 16'h0 || ds_rdata !== 16'h0 || if_rdata !== 16'h0)
      $display("FAIL rstwr_idle: dvld=%b st=%0d gnt=%b%b ivld=%b en=%b rw=%b addr=%h din=%h drd=%h ird=%h, want all 0",
               ds_valid, dut.state_q, if_gnt, ds_gnt, if_valid, mem_en, mem_rw, mem_addr, mem_din, ds_rdata, if_rdata);
    else passed++;
    // if_req held across a reset edge must not be granted on that edge
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (if_gnt !== 1'b0 || mem_en !== 1'b0)
      $display("FAIL rst_ignores_req: ig=%b en=%b, want 0 0", if_gnt, mem_en);
    else passed++;
    @(negedge clk);
    if_req = 1'b0;
    checks++;
    if (if_gnt !== 1'b1 || mem_addr !== 16'd12)
      $display("FAIL post_rst_req: ig=%b addr=%h, want 1 000c", if_gnt, mem_addr);
    else passed++;
    @(negedge clk);
    checks++;
    if (if_valid !== 1'b1 || if_rdata !== 16'h1088)
      $display("FAIL post_rst_data: vld=%b rdata=%h, want 1 1088", if_valid, if_rdata);
    else passed++;
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0;
    ds_req = 1'b0; ds_we = 1'b0; ds_addr = '0; ds_wdata = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    test_reset();
    test_idle();
    test_fetch();
    test_data_wr_rd();
    test_both();
    test_streak();
    test_rst_during_write();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
